// File: rtl/uart_core.sv
// rtl/uart_core.sv - full-duplex UART engine with programmable bit period, width, parity and stop bits
// TX and RX run as independent FSMs, each with its own bit timer.
module uart_core #(
    parameter int CLK_DIV   = 16,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 txd,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err
);
    localparam int             CW       = $clog2(CLK_DIV);
    localparam logic [CW-1:0]  BIT_END  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0]  HALF_END = CW'(CLK_DIV / 2 - 1);
    localparam logic [3:0]     DATA_END = 4'(DATA_BITS - 1);
    localparam logic [3:0]     STOP_END = 4'(STOP_BITS - 1);
    localparam logic           PAR_ODD  = (PARITY == 1);
    localparam bit             HAS_PAR  = (PARITY != 0);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

    state_t                tx_state_q, tx_state_d;
    logic [CW-1:0]         tx_cnt_q, tx_cnt_d;
    logic [3:0]            tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0]  tx_shift_q, tx_shift_d;
    logic                  tx_par_q, tx_par_d;
    logic                  txd_q, txd_d;
    logic                  tx_end;

    assign tx_end   = (tx_cnt_q == BIT_END);
    assign tx_ready = (tx_state_q == S_IDLE);
    assign txd      = txd_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            txd_q      <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_par_q   <= tx_par_d;
            txd_q      <= txd_d;
        end
    end

    // txd is registered from the next-state so the pin never glitches on decode.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_end ? '0 : tx_cnt_q + CW'(1);
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        txd_d      = txd_q;
        case (tx_state_q)
            S_IDLE: begin
                tx_cnt_d = '0;
                txd_d    = 1'b1;
                if (tx_valid) begin
                    tx_shift_d = tx_data;
                    tx_par_d   = (^tx_data) ^ PAR_ODD;
                    tx_state_d = S_START;
                    txd_d      = 1'b0;
                end
            end
            S_START: begin
                if (tx_end) begin
                    tx_state_d = S_DATA;
                    tx_bit_d   = '0;
                    txd_d      = tx_shift_q[0];
                end
            end
            S_DATA: begin
                if (tx_end) begin
                    if (tx_bit_q == DATA_END) begin
                        tx_bit_d = '0;
                        if (HAS_PAR) begin
                            tx_state_d = S_PAR;
                            txd_d      = tx_par_q;
                        end else begin
                            tx_state_d = S_STOP;
                            txd_d      = 1'b1;
                        end
                    end else begin
                        tx_bit_d   = tx_bit_q + 4'd1;
                        tx_shift_d = {1'b0, tx_shift_q[DATA_BITS-1:1]};
                        txd_d      = tx_shift_q[1];
                    end
                end
            end
            S_PAR: begin
                if (tx_end) begin
                    tx_state_d = S_STOP;
                    tx_bit_d   = '0;
                    txd_d      = 1'b1;
                end
            end
            S_STOP: begin
                if (tx_end) begin
                    if (tx_bit_q == STOP_END) tx_state_d = S_IDLE;
                    else                      tx_bit_d   = tx_bit_q + 4'd1;
                end
            end
            default: tx_state_d = S_IDLE;
        endcase
    end

    state_t                rx_state_q, rx_state_d;
    logic [CW-1:0]         rx_cnt_q, rx_cnt_d;
    logic [3:0]            rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0]  rx_shift_q, rx_shift_d;
    logic                  rx_pbit_q, rx_pbit_d;
    logic                  rx_facc_q, rx_facc_d;
    logic                  rx_armed_q, rx_armed_d;
    logic [DATA_BITS-1:0]  rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  rx_perr_q, rx_perr_d;
    logic                  rx_ferr_q, rx_ferr_d;
    logic                  rx_meta_q, rxs_q;
    logic                  rx_end;

    assign rx_end        = (rx_cnt_q == BIT_END);
    assign rx_data       = rx_data_q;
    assign rx_valid      = rx_valid_q;
    assign rx_parity_err = rx_perr_q;
    assign rx_frame_err  = rx_ferr_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_q  <= 1'b1;
            rxs_q      <= 1'b1;
            rx_state_q <= S_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_pbit_q  <= 1'b0;
            rx_facc_q  <= 1'b0;
            rx_armed_q <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_perr_q  <= 1'b0;
            rx_ferr_q  <= 1'b0;
        end else begin
            rx_meta_q  <= rxd;
            rxs_q      <= rx_meta_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_pbit_q  <= rx_pbit_d;
            rx_facc_q  <= rx_facc_d;
            rx_armed_q <= rx_armed_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_perr_q  <= rx_perr_d;
            rx_ferr_q  <= rx_ferr_d;
        end
    end

    // rx_armed blocks a held-low line (break) from looking like a new start bit.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_end ? '0 : rx_cnt_q + CW'(1);
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_pbit_d  = rx_pbit_q;
        rx_facc_d  = rx_facc_q;
        rx_armed_d = rx_armed_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        rx_perr_d  = rx_perr_q;
        rx_ferr_d  = rx_ferr_q;
        case (rx_state_q)
            S_IDLE: begin
                rx_cnt_d   = '0;
                rx_facc_d  = 1'b0;
                rx_armed_d = rx_armed_q | rxs_q;
                if (rx_armed_q && !rxs_q) rx_state_d = S_START;
            end
            S_START: begin
                if (rx_cnt_q == HALF_END) begin
                    rx_cnt_d = '0;
                    rx_bit_d = '0;
                    rx_state_d = rxs_q ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (rx_end) begin
                    rx_shift_d = {rxs_q, rx_shift_q[DATA_BITS-1:1]};
                    if (rx_bit_q == DATA_END) begin
                        rx_bit_d   = '0;
                        rx_state_d = HAS_PAR ? S_PAR : S_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 4'd1;
                    end
                end
            end
            S_PAR: begin
                if (rx_end) begin
                    rx_pbit_d  = rxs_q;
                    rx_bit_d   = '0;
                    rx_state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (rx_end) begin
                    if (rx_bit_q == STOP_END) begin
                        rx_state_d = S_IDLE;
                        rx_armed_d = 1'b0;
                        rx_valid_d = 1'b1;
                        rx_data_d  = rx_shift_q;
                        rx_perr_d  = HAS_PAR && (rx_pbit_q != ((^rx_shift_q) ^ PAR_ODD));
                        rx_ferr_d  = rx_facc_q | ~rxs_q;
                    end else begin
                        rx_bit_d  = rx_bit_q + 4'd1;
                        rx_facc_d = rx_facc_q | ~rxs_q;
                    end
                end
            end
            default: rx_state_d = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_core.sv
// tb/tb_uart_core.sv - randomized self-checking bench for uart_core against a frame-level model
module tb_uart_core;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [1:0]      tx_valid;
    logic [1:0]      rxd_drv;
    logic [1:0][7:0] tx_data;
    logic            loop;
    wire  [1:0]      tx_ready, txd, rx_valid, rx_perr, rx_ferr;
    wire  [1:0][7:0] rx_data;
    wire             rxd0 = loop ? txd[0] : rxd_drv[0];

    uart_core #(.CLK_DIV(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .rst(rst), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
        .tx_ready(tx_ready[0]), .txd(txd[0]), .rxd(rxd0), .rx_data(rx_data[0]),
        .rx_valid(rx_valid[0]), .rx_parity_err(rx_perr[0]), .rx_frame_err(rx_ferr[0]));

    uart_core #(.CLK_DIV(12), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) dut1 (
        .clk(clk), .rst(rst), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
        .tx_ready(tx_ready[1]), .txd(txd[1]), .rxd(rxd_drv[1]), .rx_data(rx_data[1]),
        .rx_valid(rx_valid[1]), .rx_parity_err(rx_perr[1]), .rx_frame_err(rx_ferr[1]));

    function automatic int cd(int d); return (d == 0) ? 16 : 12; endfunction
    function automatic int pm(int d); return (d == 0) ? 0 : 2;   endfunction
    function automatic int sb(int d); return (d == 0) ? 1 : 2;   endfunction
    function automatic int nb(int d); return 9 + ((pm(d) != 0) ? 1 : 0) + sb(d); endfunction

    // Frame as the line carries it, bit 0 first: start, data LSB first, parity, stops.
    function automatic logic [15:0] mkframe(int d, logic [7:0] data, bit flip, logic [1:0] stops);
        logic [15:0] f = '1;
        int k = 9;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[1+i] = data[i];
        if (pm(d) != 0) begin
            f[9] = (^data) ^ (pm(d) == 1) ^ flip;
            k = 10;
        end
        for (int s = 0; s < sb(d); s++) f[k+s] = stops[s];
        return f;
    endfunction

    typedef struct {
        logic [7:0] data;
        logic       pe;
        logic       fe;
        int         lo;
        int         hi;
    } exp_t;

    exp_t q0[$], q1[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    task automatic chk(string nm, int d, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d got=%0h want=%0h at cycle %0d", nm, d, act, exp, cyc);
        end
    endtask

    function automatic int sb_size(int d); return (d == 0) ? q0.size() : q1.size(); endfunction
    function automatic exp_t sb_front(int d); return (d == 0) ? q0[0] : q1[0]; endfunction
    task automatic sb_push(int d, exp_t e);
        if (d == 0) q0.push_back(e); else q1.push_back(e);
    endtask
    task automatic sb_drop(int d);
        if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // TX model: position within the current frame, -1 when idle.
    int          tpos[2] = '{-1, -1};
    logic [15:0] tfr[2];
    logic [7:0]  tdat[2];
    always @(posedge clk or negedge rst) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst) tpos[d] <= -1;
            else if (tpos[d] >= 0) tpos[d] <= (tpos[d] + 1 == nb(d) * cd(d)) ? -1 : tpos[d] + 1;
            else if (tx_valid[d]) begin
                tpos[d] <= 0;
                tfr[d]  <= mkframe(d, tx_data[d], 1'b0, 2'b11);
                tdat[d] <= tx_data[d];
            end
        end
    end

    logic [7:0] last_data[2] = '{8'h00, 8'h00};
    logic       last_pe[2]   = '{1'b0, 1'b0};
    logic       last_fe[2]   = '{1'b0, 1'b0};
    logic       prevv[2]     = '{1'b0, 1'b0};

    always @(negedge clk) begin
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            chk("txd", d, txd[d], (tpos[d] < 0) ? 1'b1 : tfr[d][tpos[d] / cd(d)]);
            chk("tx_ready", d, tx_ready[d], tpos[d] < 0);
            if (!rst) begin
                if (d == 0) q0.delete(); else q1.delete();
                last_data[d] = 8'h00;
                last_pe[d]   = 1'b0;
                last_fe[d]   = 1'b0;
            end else if (d == 0 && loop && tpos[0] == 0) begin
                e.data = tdat[0]; e.pe = 1'b0; e.fe = 1'b0;
                e.lo = cyc + (nb(0) - 1) * cd(0);
                e.hi = cyc + nb(0) * cd(0) + 6;
                sb_push(0, e);
            end
            if (rx_valid[d]) begin
                chk("rx_pulse_width", d, prevv[d], 0);
                if (sb_size(d) == 0) chk("rx_spurious", d, rx_valid[d], 0);
                else begin
                    e = sb_front(d);
                    sb_drop(d);
                    chk("rx_timing", d, (cyc >= e.lo) && (cyc <= e.hi), 1);
                    last_data[d] = e.data;
                    last_pe[d]   = e.pe;
                    last_fe[d]   = e.fe;
                end
            end else if (sb_size(d) > 0 && cyc > sb_front(d).hi) begin
                chk("rx_missing", d, rx_valid[d], 1);
                sb_drop(d);
            end
            chk("rx_data", d, rx_data[d], last_data[d]);
            chk("rx_parity_err", d, rx_perr[d], last_pe[d]);
            chk("rx_frame_err", d, rx_ferr[d], last_fe[d]);
            prevv[d] = rx_valid[d];
        end
    end

    task automatic send(int d, logic [7:0] data);
        int w = 0;
        @(negedge clk);
        while (!tx_ready[d] && w < 5000) begin
            @(negedge clk);
            w++;
        end
        if (w >= 5000) chk("tx_ready_wait", d, tx_ready[d], 1);
        #1;
        tx_valid[d] = 1'b1;
        tx_data[d]  = data;
        @(negedge clk);
        #1;
        tx_valid[d] = 1'b0;
        tx_data[d]  = 8'($urandom);
    endtask

    task automatic drive_rx(int d, logic [7:0] data, bit flip, logic [1:0] stops, int gap);
        exp_t        e;
        logic [15:0] f = mkframe(d, data, flip, stops);
        @(negedge clk);
        #1;
        e.data = data;
        e.pe   = (pm(d) != 0) && flip;
        e.fe   = (sb(d) == 1) ? ~stops[0] : ~(stops[0] & stops[1]);
        e.lo   = cyc + (nb(d) - 1) * cd(d);
        e.hi   = cyc + nb(d) * cd(d) + 6;
        sb_push(d, e);
        for (int k = 0; k < nb(d); k++) begin
            rxd_drv[d] = f[k];
            repeat (cd(d)) begin
                @(negedge clk);
                #1;
            end
        end
        rxd_drv[d] = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    task automatic drain();
        int w = 0;
        while ((q0.size() + q1.size()) > 0 && w < 4000) begin
            @(negedge clk);
            w++;
        end
        chk("drain", 0, q0.size() + q1.size(), 0);
        @(negedge clk);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0]  a5fr;
        logic [15:0] rfr;
        int          rdy_at;
        int          seen;
        rst = 1'b0; tx_valid = '0; tx_data = '0; rxd_drv = 2'b11; loop = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_txd", 0, txd[0], 1);
        chk("rst_tx_ready", 0, tx_ready[0], 1);
        chk("rst_rx_valid", 0, rx_valid[0], 0);
        chk("rst_rx_data", 1, rx_data[1], 0);
        #1 rst = 1'b1;
        repeat (4) @(negedge clk);

        // 8'hA5 on the 8N1 instance, pinned to literal line levels.
        a5fr = {1'b1, 8'hA5, 1'b0};
        send(0, 8'hA5);
        rdy_at = -1;
        for (int i = 1; i < 200; i++) begin
            @(negedge clk);
            if (i < 160 && (i % 16) == 8) chk("a5_bit", 0, txd[0], a5fr[i/16]);
            if (tx_ready[0] && rdy_at < 0) rdy_at = i;
        end
        chk("a5_ready_cycles", 0, rdy_at, 160);

        loop = 1'b1;
        send(0, 8'h00);
        send(0, 8'hFF);
        send(0, 8'h3C);
        drain();
        chk("loop_last_data", 0, rx_data[0], 8'h3C);
        loop = 1'b0;

        // Short low pulse must be rejected as a glitch.
        seen = 0;
        @(negedge clk); #1 rxd_drv[0] = 1'b0;
        repeat (5) @(negedge clk);
        #1 rxd_drv[0] = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            seen += rx_valid[0];
        end
        chk("glitch_no_valid", 0, seen, 0);
        drive_rx(0, 8'h81, 1'b0, 2'b11, 20);
        drain();
        chk("after_glitch_data", 0, rx_data[0], 8'h81);

        // Reset during TX data bit 3 and RX data bit 4.
        rfr = mkframe(0, 8'h96, 1'b0, 2'b11);
        for (int c = 0; c < 88; c++) begin
            @(negedge clk);
            #1;
            rxd_drv[0] = rfr[c/16];
            if (c == 16) begin tx_valid[0] = 1'b1; tx_data[0] = 8'h5A; end
            if (c == 17) tx_valid[0] = 1'b0;
        end
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rst_async_txd", 0, txd[0], 1);
        chk("rst_async_ready", 0, tx_ready[0], 1);
        chk("rst_async_rx_valid", 0, rx_valid[0], 0);
        rxd_drv[0] = 1'b1;
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;
        repeat (5) @(negedge clk);
        loop = 1'b1;
        send(0, 8'hC3);
        drain();
        chk("post_rst_data", 0, rx_data[0], 8'hC3);
        loop = 1'b0;

        // Even parity, two stop bits instance.
        send(1, 8'h07);
        for (int i = 1; i < 144; i++) begin
            @(negedge clk);
            if (i == 6)   chk("p07_start", 1, txd[1], 0);
            if (i == 114) chk("p07_parity", 1, txd[1], 1);
            if (i == 126 || i == 138) chk("p07_stop", 1, txd[1], 1);
        end
        drive_rx(1, 8'h07, 1'b1, 2'b11, 24);
        drain();
        chk("perr_flag", 1, rx_perr[1], 1);
        chk("perr_data", 1, rx_data[1], 8'h07);
        drive_rx(1, 8'hA3, 1'b0, 2'b01, 24);
        drain();
        chk("ferr_flag", 1, rx_ferr[1], 1);
        drive_rx(1, 8'h55, 1'b0, 2'b11, 24);
        drain();
        chk("clean_ferr", 1, rx_ferr[1], 0);
        chk("clean_data", 1, rx_data[1], 8'h55);

        // Concurrent random traffic: looped TX/RX on dut0, free TX and injected RX errors on dut1.
        loop = 1'b1;
        fork
            begin
                for (int i = 0; i < 3000; i++) begin
                    @(negedge clk);
                    #1;
                    tx_valid[0] = ($urandom % 8) == 0;
                    tx_data[0]  = 8'($urandom);
                end
                tx_valid[0] = 1'b0;
            end
            begin
                for (int i = 0; i < 3000; i++) begin
                    @(negedge clk);
                    #1;
                    tx_valid[1] = ($urandom % 8) == 0;
                    tx_data[1]  = 8'($urandom);
                end
                tx_valid[1] = 1'b0;
            end
            begin
                for (int n = 0; n < 15; n++)
                    drive_rx(1, 8'($urandom), ($urandom % 4) == 0,
                             {($urandom % 4) != 0, ($urandom % 4) != 0},
                             int'($urandom_range(1, 30)));
            end
        join
        repeat (200) @(negedge clk);
        drain();
        loop = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
